// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the 32/16 sequential restoring divider.
package div_pkg;
   localparam int DIV_W = 16;
   localparam int CNT_W = $clog2(DIV_W);
   localparam logic [DIV_W-1:0] OVF_FILL = '1;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/div_32by16_seq_if.sv
// div_32by16_seq_if: operand/result valid-ready bus of the sequential divider.
interface div_32by16_seq_if;
   import div_pkg::*;
   logic                 in_valid;
   logic                 in_ready;
   logic [2*DIV_W-1:0]   in0;
   logic [DIV_W-1:0]     in1;
   logic                 out_valid;
   logic                 out_ready;
   logic [DIV_W-1:0]     out0;
   logic [DIV_W-1:0]     out1;
   logic                 ovf;
   modport master (output in_valid, in0, in1, out_ready,
                   input  in_ready, out_valid, out0, out1, ovf);
   modport slave  (input  in_valid, in0, in1, out_ready,
                   output in_ready, out_valid, out0, out1, ovf);
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
module div_step
   import div_pkg::*;
(
   input  logic [DIV_W-1:0] i_rem,
   input  logic             i_msb,
   input  logic [DIV_W-1:0] i_div,
   output logic [DIV_W-1:0] o_rem,
   output logic             o_qbit
);
   logic [DIV_W:0] w_rem17;
   logic [DIV_W:0] w_diff;
   assign w_rem17 = {i_rem, i_msb};
   assign w_diff  = w_rem17 - {1'b0, i_div};
   // rem17 < 2*div, so a non-negative difference always has a clear top bit
   assign o_qbit  = ~w_diff[DIV_W];
   assign o_rem   = o_qbit ? w_diff[DIV_W-1:0] : w_rem17[DIV_W-1:0];
endmodule

// File: rtl/div_32by16_seq.sv
// div_32by16_seq: 32-bit by 16-bit sequential restoring divider, one quotient bit per clock.
module div_32by16_seq
   import div_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   div_32by16_seq_if.slave bus
);
   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [DIV_W-1:0]   r_rem;
   logic [DIV_W-1:0]   r_quo;
   logic [DIV_W-1:0]   r_div;
   logic [DIV_W-1:0]   r_out0;
   logic [DIV_W-1:0]   r_out1;
   logic               r_ovf;
   logic               r_out_valid;
   logic               r_in_ready;
   logic [DIV_W-1:0]   w_rem;
   logic               w_qbit;
   logic [DIV_W-1:0]   w_quo_nxt;
   logic               w_ovf;
   div_step u_step (
      .i_rem  (r_rem),
      .i_msb  (r_quo[DIV_W-1]),
      .i_div  (r_div),
      .o_rem  (w_rem),
      .o_qbit (w_qbit)
   );
   // r_quo shifts out the low dividend bits while shifting in quotient bits
   assign w_quo_nxt = {r_quo[DIV_W-2:0], w_qbit};
   assign w_ovf     = bus.in0[2*DIV_W-1:DIV_W] >= bus.in1;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_div       <= '0;
         r_out0      <= '0;
         r_out1      <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         case (r_state)
            IDLE: if (bus.in_valid && r_in_ready) begin
               r_in_ready <= 1'b0;
               if (w_ovf) begin
                  r_state     <= DONE;
                  r_out0      <= OVF_FILL;
                  r_out1      <= OVF_FILL;
                  r_ovf       <= 1'b1;
                  r_out_valid <= 1'b1;
               end else begin
                  r_state <= BUSY;
                  r_rem   <= bus.in0[2*DIV_W-1:DIV_W];
                  r_quo   <= bus.in0[DIV_W-1:0];
                  r_div   <= bus.in1;
                  r_cnt   <= '0;
               end
            end
            BUSY: begin
               r_rem <= w_rem;
               r_quo <= w_quo_nxt;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(DIV_W-1)) begin
                  r_state     <= DONE;
                  r_out0      <= w_quo_nxt;
                  r_out1      <= w_rem;
                  r_ovf       <= 1'b0;
                  r_out_valid <= 1'b1;
               end
            end
            DONE: if (bus.out_ready) begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out0      = r_out0;
   assign bus.out1      = r_out1;
   assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_div_32by16_seq.sv
// tb_div_32by16_seq: vector table, corner-case sequences and random ops against an arithmetic model.
module tb_div_32by16_seq;
   import div_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   div_32by16_seq_if bus ();
   div_32by16_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   int n_tests = 0;
   int n_fail = 0;
   typedef struct {
      logic [31:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic [15:0] r;
      logic        f;
      int          lat;
   } vec_t;
   vec_t tv[8];
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // quotient must fit 16 bits and divisor must be non-zero, else saturate
   task automatic model(input logic [31:0] a, input logic [15:0] b,
                        output logic [15:0] q, output logic [15:0] r, output logic f);
      if (b == 0 || (a / {16'd0, b}) > 32'hFFFF) begin
         q = 16'hFFFF; r = 16'hFFFF; f = 1'b1;
      end else begin
         q = 16'(a / {16'd0, b}); r = 16'(a % {16'd0, b}); f = 1'b0;
      end
   endtask
   task automatic run_op(input logic [31:0] a, input logic [15:0] b, input int hold,
                         output logic [15:0] q, output logic [15:0] r, output logic f, output int lat);
      int w = 0;
      @(negedge clk);
      while (!bus.in_ready && w < 50) begin @(negedge clk); w++; end
      if (w >= 50) check("in_ready_wait", 64'(bus.in_ready), 64'd1);
      bus.in0 = a; bus.in1 = b; bus.in_valid = 1'b1;
      @(posedge clk); #1 bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 40) begin @(posedge clk); #1 lat++; end
      q = bus.out0; r = bus.out1; f = bus.ovf;
      repeat (hold) @(negedge clk);
      @(negedge clk) bus.out_ready = 1'b1;
      @(posedge clk); #1 bus.out_ready = 1'b0;
   endtask
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [15:0] q, r, eq, er, a16, b;
      logic        f, ef;
      logic [31:0] a;
      int          lat;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in0 = '0; bus.in1 = '0;
      tv[0] = '{32'd100,        16'd7,      16'd14,     16'd2,      1'b0, 17};
      tv[1] = '{32'hFFFE0001,   16'hFFFF,   16'hFFFF,   16'd0,      1'b0, 17};
      tv[2] = '{32'd5,          16'd0,      16'hFFFF,   16'hFFFF,   1'b1, 1};
      tv[3] = '{32'h00010000,   16'd1,      16'hFFFF,   16'hFFFF,   1'b1, 1};
      tv[4] = '{32'd0,          16'd1,      16'd0,      16'd0,      1'b0, 17};
      tv[5] = '{32'h0000FFFF,   16'd1,      16'hFFFF,   16'd0,      1'b0, 17};
      tv[6] = '{32'h0001FFFF,   16'd2,      16'hFFFF,   16'd1,      1'b0, 17};
      tv[7] = '{32'hFFFFFFFF,   16'hFFFF,   16'hFFFF,   16'hFFFF,   1'b1, 1};
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready",  64'(bus.in_ready),  64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out0",      64'(bus.out0),      64'd0);
      check("rst_out1",      64'(bus.out1),      64'd0);
      check("rst_ovf",       64'(bus.ovf),       64'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         run_op(tv[i].a, tv[i].b, 0, q, r, f, lat);
         check($sformatf("vec%0d_q", i),   64'(q),   64'(tv[i].q));
         check($sformatf("vec%0d_r", i),   64'(r),   64'(tv[i].r));
         check($sformatf("vec%0d_ovf", i), 64'(f),   64'(tv[i].f));
         check($sformatf("vec%0d_lat", i), 64'(lat), 64'(tv[i].lat));
         check($sformatf("vec%0d_post_valid", i), 64'(bus.out_valid), 64'd0);
         check($sformatf("vec%0d_post_ready", i), 64'(bus.in_ready),  64'd1);
      end
      // operands offered while busy must be ignored; result must hold while stalled
      @(negedge clk);
      bus.in0 = 32'd1000; bus.in1 = 16'd33; bus.in_valid = 1'b1;
      @(posedge clk); #1 bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 bus.in0 = 32'd5; bus.in1 = 16'd0; bus.in_valid = 1'b1;
      check("busy_in_ready", 64'(bus.in_ready), 64'd0);
      repeat (2) @(posedge clk);
      #1 bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 40) begin @(posedge clk); #1 lat++; end
      check("stall_valid", 64'(bus.out_valid), 64'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("stall%0d_q", k),     64'(bus.out0),      64'd30);
         check($sformatf("stall%0d_r", k),     64'(bus.out1),      64'd10);
         check($sformatf("stall%0d_ovf", k),   64'(bus.ovf),       64'd0);
         check($sformatf("stall%0d_ready", k), 64'(bus.in_ready),  64'd0);
         check($sformatf("stall%0d_valid", k), 64'(bus.out_valid), 64'd1);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1 bus.out_ready = 1'b0;
      check("stall_post_valid", 64'(bus.out_valid), 64'd0);
      check("stall_post_ready", 64'(bus.in_ready),  64'd1);
      check("idle_keep_q", 64'(bus.out0), 64'd30);
      // reset mid-iteration aborts the operation immediately
      @(negedge clk);
      bus.in0 = 32'd100; bus.in1 = 16'd7; bus.in_valid = 1'b1;
      @(posedge clk); #1 bus.in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_out_valid", 64'(bus.out_valid), 64'd0);
      check("abort_out0",      64'(bus.out0),      64'd0);
      check("abort_out1",      64'(bus.out1),      64'd0);
      check("abort_in_ready",  64'(bus.in_ready),  64'd1);
      @(negedge clk) rst_n = 1'b1;
      run_op(32'd100, 16'd7, 0, q, r, f, lat);
      check("after_abort_q",   64'(q),   64'd14);
      check("after_abort_r",   64'(r),   64'd2);
      check("after_abort_lat", 64'(lat), 64'd17);
      for (int i = 0; i < 1500; i++) begin
         b = 16'($urandom_range(1, 16'hFFFF));
         if (i % 2 == 0) begin
            a16 = 16'($urandom);
            a = a16 * b;
            eq = a16; er = 16'd0; ef = 1'b0;
         end else begin
            a = (i % 5 == 1) ? $urandom : {16'($urandom_range(0, b - 1)), 16'($urandom)};
            if (i % 7 == 1) b = 16'($urandom_range(0, 3));
            model(a, b, eq, er, ef);
         end
         run_op(a, b, $urandom_range(0, 2), q, r, f, lat);
         check($sformatf("rand%0d a=%0h b=%0h {q,r,ovf}", i, a, b), {31'd0, q, r, f}, {31'd0, eq, er, ef});
         check($sformatf("rand%0d_lat", i), 64'(lat), ef ? 64'd1 : 64'd17);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
